// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for a common-anode multi-digit
// 7-segment display that shares one BCD-to-7-segment decoder.
//
// Each digit owns a slot of SCAN_DIV clocks. The first DEAD clocks of a
// slot are blanked (BLANK) while bcd_sel already carries the next digit so
// the decoder settles; the rest of the slot lights the digit (SHOW).
// Digits and decimal points are copied into shadow registers once per
// frame (at slot 0 of digit 0) so a changing count never tears.
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   en           scan enable; 0 turns every digit off
//   digits_in    BCD digits, digit i at [4i+3:4i], digit 0 rightmost
//   dp_in        per-digit decimal point, active-high
//   bcd_sel      BCD code to the shared decoder
//   an_n         digit enables, active-low
//   dp_n         decimal point, active-low
//   digit_idx    index of the current slot's digit
//   frame_start  one-cycle pulse when the shadow snapshot is taken
//   state_dbg    current scan state (IDLE=0, BLANK=1, SHOW=2)
//
// Handshake: there is no valid/ready pair; frame_start qualifies the
// snapshot and all outputs are registered, updating only on clk edges
// (or immediately on rst).
module seg_scan_ctrl #(
  parameter  int DIGITS   = 4,
  parameter  int SCAN_DIV = 50000,
  parameter  int DEAD     = 16,
  parameter  int LZ_BLANK = 1,
  localparam int IW       = (DIGITS > 2) ? $clog2(DIGITS) : 1,
  localparam int CW       = $clog2(SCAN_DIV)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [3:0]            bcd_sel,
  output logic [DIGITS-1:0]     an_n,
  output logic                  dp_n,
  output logic [IW-1:0]         digit_idx,
  output logic                  frame_start,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [IW-1:0]         idx_q;
  logic [4*DIGITS-1:0]   sh_dig_q;
  logic [DIGITS-1:0]     sh_dp_q;
  logic [3:0]            bcd_q;
  logic [DIGITS-1:0]     an_n_q;
  logic                  dp_n_q;
  logic                  fs_q;

  logic [CW-1:0]         cnt_inc;
  logic [IW-1:0]         idx_inc;
  logic [3:0]            cur_dig;
  logic [3:0]            nxt_dig;
  logic                  cur_dp;
  logic                  cur_sup;
  logic [DIGITS-1:0]     sup;
  logic                  zero_run;
  logic [DIGITS-1:0]     lit_mask;

  always_comb begin
    cnt_inc  = cnt_q + CW'(1);
    idx_inc  = idx_q + IW'(1);
    cur_dig  = 4'd0;
    nxt_dig  = 4'd0;
    cur_dp   = 1'b0;
    cur_sup  = 1'b0;
    sup      = '0;
    zero_run = 1'b1;
    // A digit is a leading zero only if it and everything to its left are
    // zero with no decimal point; scanning from the top keeps that running.
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (sh_dig_q[4*i +: 4] == 4'd0) & ~sh_dp_q[i];
      sup[i]   = (LZ_BLANK != 0) & zero_run;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_dig = sh_dig_q[4*i +: 4];
        cur_dp  = sh_dp_q[i];
        cur_sup = sup[i];
      end
      if (idx_inc == IW'(i)) begin
        nxt_dig = sh_dig_q[4*i +: 4];
      end
    end
    lit_mask = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_dig_q <= '0;
      sh_dp_q  <= '0;
      bcd_q    <= 4'd0;
      an_n_q   <= '1;
      dp_n_q   <= 1'b1;
      fs_q     <= 1'b0;
    end else if (!en) begin
      // Abandon the slot at once; bcd_sel and digit_idx hold.
      state_q <= IDLE;
      an_n_q  <= '1;
      dp_n_q  <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      fs_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q  <= BLANK;
          cnt_q    <= '0;
          idx_q    <= '0;
          sh_dig_q <= digits_in;
          sh_dp_q  <= dp_in;
          bcd_q    <= digits_in[3:0];
          an_n_q   <= '1;
          dp_n_q   <= 1'b1;
          fs_q     <= 1'b1;
        end
        BLANK, SHOW: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            an_n_q  <= '1;
            dp_n_q  <= 1'b1;
            if (idx_q == IDX_LAST) begin
              idx_q    <= '0;
              sh_dig_q <= digits_in;
              sh_dp_q  <= dp_in;
              bcd_q    <= digits_in[3:0];
              fs_q     <= 1'b1;
            end else begin
              idx_q <= idx_inc;
              bcd_q <= nxt_dig;
            end
          end else begin
            cnt_q <= cnt_inc;
            bcd_q <= cur_dig;
            if (cnt_inc >= CNT_DEAD) begin
              state_q <= SHOW;
              an_n_q  <= cur_sup ? '1 : lit_mask;
              dp_n_q  <= cur_sup ? 1'b1 : ~cur_dp;
            end else begin
              state_q <= BLANK;
              an_n_q  <= '1;
              dp_n_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          an_n_q  <= '1;
          dp_n_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bcd_sel     = bcd_q;
  assign an_n        = an_n_q;
  assign dp_n        = dp_n_q;
  assign digit_idx   = idx_q;
  assign frame_start = fs_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: two instances (LZ_BLANK=0 and 1) share the
// same stimulus. A frame-time reference model predicts every output vector
// {bcd_sel, an_n, dp_n, digit_idx, frame_start} per clock and queues it;
// a monitor pops and compares one entry per clock.
module tb_seg_scan_ctrl;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 8;
  localparam int DEAD     = 2;
  localparam int FRAME    = DIGITS * SCAN_DIV;
  localparam int W        = 12;
  localparam logic [W-1:0] RST_VEC = {4'h0, 4'hF, 1'b1, 2'b00, 1'b0};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        en = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;

  logic [3:0] bcd0, bcd1, an0, an1;
  logic       dpn0, dpn1, fs0, fs1;
  logic [1:0] idx0, idx1, st0, st1;

  seg_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEAD(DEAD), .LZ_BLANK(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .dp_in(dp_in),
    .bcd_sel(bcd0), .an_n(an0), .dp_n(dpn0), .digit_idx(idx0),
    .frame_start(fs0), .state_dbg(st0)
  );

  seg_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEAD(DEAD), .LZ_BLANK(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .dp_in(dp_in),
    .bcd_sel(bcd1), .an_n(an1), .dp_n(dpn1), .digit_idx(idx1),
    .frame_start(fs1), .state_dbg(st1)
  );

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h exp=%h (bcd,an_n,dp_n,idx,fs)", name, $time, got, exp);
    end
  endtask

  // reference model: position within the frame decides everything
  bit         m_active = 1'b0;
  int         m_t = 0;
  int         m_idx = 0;
  logic [3:0] m_bcd = 4'h0;
  logic [3:0] m_snap[DIGITS];
  bit         m_sdp[DIGITS];

  function automatic logic [W-1:0] model_vec(input bit lz);
    int  pos;
    bit  lit;
    bit  sup;
    logic [3:0] an;
    logic dpn;
    if (!m_active) return {m_bcd, 4'hF, 1'b1, 2'(m_idx), 1'b0};
    pos = m_t % SCAN_DIV;
    sup = 1'b0;
    if (lz && m_idx > 0) begin
      sup = 1'b1;
      for (int j = m_idx; j < DIGITS; j++)
        if (m_snap[j] != 4'h0 || m_sdp[j]) sup = 1'b0;
    end
    lit = (pos >= DEAD) && !sup;
    an  = lit ? ~(4'(1) << m_idx) : 4'hF;
    dpn = lit ? ~m_sdp[m_idx] : 1'b1;
    return {m_bcd, an, dpn, 2'(m_idx), (m_t == 0)};
  endfunction

  task automatic model_step();
    if (rst) begin
      m_active = 1'b0;
      m_bcd    = 4'h0;
      m_idx    = 0;
      for (int i = 0; i < DIGITS; i++) begin
        m_snap[i] = 4'h0;
        m_sdp[i]  = 1'b0;
      end
    end else if (!en) begin
      m_active = 1'b0;
    end else begin
      if (!m_active) begin
        m_active = 1'b1;
        m_t      = 0;
      end else begin
        m_t = (m_t + 1) % FRAME;
      end
      if (m_t == 0) begin
        for (int i = 0; i < DIGITS; i++) begin
          m_snap[i] = digits_in[4*i +: 4];
          m_sdp[i]  = dp_in[i];
        end
      end
      m_idx = m_t / SCAN_DIV;
      m_bcd = m_snap[m_idx];
    end
    exp0_q.push_back(model_vec(1'b0));
    exp1_q.push_back(model_vec(1'b1));
  endtask

  // monitor: one expected vector per clock once stimulus is running
  always @(posedge clk) begin
    #1;
    if (exp0_q.size() > 0) check("scan_lz0", {bcd0, an0, dpn0, idx0, fs0}, exp0_q.pop_front());
    if (exp1_q.size() > 0) check("scan_lz1", {bcd1, an1, dpn1, idx1, fs1}, exp1_q.pop_front());
  end

  // driver tasks: inputs change 2 time units after the edge
  task automatic cyc(input bit e, input logic [15:0] d, input logic [3:0] p);
    @(posedge clk);
    #2;
    rst       = 1'b0;
    en        = e;
    digits_in = d;
    dp_in     = p;
    model_step();
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_lz0", {bcd0, an0, dpn0, idx0, fs0}, RST_VEC);
    check("async_rst_lz1", {bcd1, an1, dpn1, idx1, fs1}, RST_VEC);
    model_step();
  endtask

  task automatic run(input int n, input logic [15:0] d, input logic [3:0] p);
    cyc(1'b0, d, p);
    for (int i = 0; i < n; i++) cyc(1'b1, d, p);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    v = 16'h0;
    for (int k = 0; k < DIGITS; k++)
      v = (v << 4) | 16'(($urandom_range(0, 1) != 0) ? 0 : $urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    logic [15:0] rd;
    logic [3:0]  rp;
    #1 rst = 1'b1;
    #2;
    check("reset_lz0", {bcd0, an0, dpn0, idx0, fs0}, RST_VEC);
    check("reset_lz1", {bcd1, an1, dpn1, idx1, fs1}, RST_VEC);

    // basic scan, two full frames plus
    run(70, 16'h1234, 4'h0);

    // snapshot: change inputs during SHOW of digit 1
    cyc(1'b0, 16'h1234, 4'h0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 16'h1234, 4'h0);
    for (int i = 0; i < 50; i++) cyc(1'b1, 16'h5678, 4'h0);

    // leading zeros and invalid code
    run(40, 16'h0040, 4'h0);
    run(40, 16'h0000, 4'h0);
    run(40, 16'h0005, 4'b0100);
    run(40, 16'h00A0, 4'h0);

    // enable drop during SHOW of digit 1, then re-enable
    run(12, 16'h9876, 4'b0010);
    cyc(1'b0, 16'h9876, 4'b0010);
    cyc(1'b0, 16'h9876, 4'b0010);
    for (int i = 0; i < 40; i++) cyc(1'b1, 16'h9876, 4'b0010);

    // asynchronous reset during SHOW of digit 2
    run(20, 16'h1234, 4'h0);
    async_reset();
    for (int i = 0; i < 40; i++) cyc(1'b1, 16'h1234, 4'h0);

    // randomized traffic
    rd = rand_digits();
    rp = 4'h0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) rd = rand_digits();
      if ($urandom_range(0, 29) == 0) rp = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) async_reset();
      else cyc($urandom_range(0, 99) >= 3, rd, rp);
    end

    repeat (3) @(posedge clk);
    #3;
    n_cmp++;
    if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain left0=%0d left1=%0d required=0", exp0_q.size(), exp1_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
